// File: rtl/pb_debounce_evt.sv
// pb_debounce_evt: conditions a raw active-low push button into single-cycle
// press / release / long-press events plus a debounced "held" level.
// Optional auto-repeat pulses are compiled in with the AUTO_REPEAT_EN macro;
// without it rpt is tied low and the repeat counter does not exist.
module pb_debounce_evt #(
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic pressed,
    output logic released,
    output logic long_press,
    output logic rpt,
    output logic held
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    // Parameter sanity: a one-cycle debounce or a long-press shorter than the
    // debounce window makes the event ordering meaningless.
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("pb_debounce_evt: DB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
        $error("pb_debounce_evt: LONG_CYCLES must exceed DB_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_rpt
        $error("pb_debounce_evt: REPEAT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } state_e;

    logic              sync1_q, sync2_q;
    logic              pb_s;
    state_e            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pressed_q, pressed_d;
    logic              released_q, released_d;
    logic              long_q, long_d;
    logic              held_q, held_d;
    logic              accept_rel;
    logic              in_hold;

    // Two-flop synchronizer; presets to "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here keep the two stages as two real flops.
            sync1_q <= PB;
            sync2_q <= sync1_q;
        end
    end

    assign pb_s    = sync2_q;
    assign in_hold = (state_q == ST_DOWN) || (state_q == ST_WAIT_UP);

    // Debounce FSM next-state, debounce/hold counters and event decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        long_d     = 1'b0;
        held_d     = held_q;
        accept_rel = 1'b0;

        case (state_q)
            ST_UP: begin
                if (!pb_s) begin
                    state_d  = ST_WAIT_DN;
                    db_cnt_d = DB_W'(1);
                end
            end
            ST_WAIT_DN: begin
                if (pb_s) begin
                    state_d  = ST_UP;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    state_d    = ST_DOWN;
                    db_cnt_d   = '0;
                    pressed_d  = 1'b1;
                    held_d     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_DOWN: begin
                if (pb_s) begin
                    state_d  = ST_WAIT_UP;
                    db_cnt_d = DB_W'(1);
                end
            end
            ST_WAIT_UP: begin
                if (!pb_s) begin
                    state_d  = ST_DOWN;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    state_d    = ST_UP;
                    db_cnt_d   = '0;
                    released_d = 1'b1;
                    held_d     = 1'b0;
                    accept_rel = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = ST_UP;
                db_cnt_d = '0;
                held_d   = 1'b0;
            end
        endcase

        // Hold timer runs while accepted-pressed (bounces included) and saturates,
        // so long_press can fire only once per hold.
        if (in_hold && (hold_cnt_q != HOLD_W'(LONG_CYCLES))) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if ((hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) && !accept_rel) begin
                long_d = 1'b1;
            end
        end
    end

    // State, counters and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UP;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

    assign pressed    = pressed_q;
    assign released   = released_q;
    assign long_press = long_q;
    assign held       = held_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_q, rpt_d;

    // Repeat timer starts once the hold timer has saturated (long press done).
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_d     = 1'b0;
        if (accept_rel || pressed_d) begin
            rpt_cnt_d = '0;
        end else if (in_hold && (hold_cnt_q == HOLD_W'(LONG_CYCLES))) begin
            if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
                rpt_cnt_d = '0;
                rpt_d     = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    // Repeat counter and registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = 1'b0;
`endif

endmodule
